mem_access_ctrl: RTL and testbench

// Data-memory access controller for the rv32i core, sitting between the memory stage and the data bus.
// - Sequences one load or store per instruction over a req/gnt/rvalid bus with variable latency.
// - Generates byte enables and lane-replicated store data, and aligns and extends load data.
// - Stalls the pipeline until the access completes; flags misaligned, illegal-size and timed-out accesses.

---
 rtl/mem_access_ctrl.sv | 132 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: rv32i data-memory access sequencer over a req/gnt/rvalid bus
module mem_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_en_i,
   input  logic        mem_we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] write_data_i,
   output logic        stall_o,
   output logic        done_o,
   output logic [31:0] load_data_o,
   output logic        fault_o,
   output logic [1:0]  fault_cause_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i
);
   localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
   state_t state, state_n;
   logic [31:0] addr_q, wd_q, load_q, load_n, shifted, ext;
   logic [2:0] f3_q;
   logic we_q, illegal, misaligned, timeout, busy, req_st;
   logic [CW-1:0] cnt;
   always_comb begin
      illegal    = mem_we_i ? (funct3_i[2] | &funct3_i[1:0])
                            : (&funct3_i[1:0] | (funct3_i[2] & funct3_i[1]));
      misaligned = (funct3_i[1:0] == 2'b01 & addr_i[0]) | (funct3_i[1:0] == 2'b10 & |addr_i[1:0]);
      busy       = state == REQ || state == RESP;
      req_st     = state == REQ;
      timeout    = TIMEOUT_CYCLES != 0 && busy && cnt == CW'(TIMEOUT_CYCLES);
      shifted    = bus_rdata_i >> {addr_q[1:0], 3'b000};
      ext        = f3_q == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]} :
                   f3_q == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]} :
                   f3_q == 3'b100 ? {24'd0, shifted[7:0]} :
                   f3_q == 3'b101 ? {16'd0, shifted[15:0]} : shifted;
   end
   // Bus fields are driven only while requesting so idle/reset outputs read as zero.
   always_comb begin
      bus_we_o    = req_st & we_q;
      bus_addr_o  = req_st ? {addr_q[31:2], 2'b00} : 32'd0;
      bus_be_o    = !req_st ? 4'b0000 :
                    f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                    f3_q[1:0] == 2'b01 ? 4'b0011 << addr_q[1:0] : 4'b1111;
      bus_wdata_o = !req_st ? 32'd0 :
                    f3_q[1:0] == 2'b00 ? {4{wd_q[7:0]}} :
                    f3_q[1:0] == 2'b01 ? {2{wd_q[15:0]}} : wd_q;
      load_data_o = load_q;
   end
   always_comb begin
      state_n       = state;
      load_n        = load_q;
      stall_o       = 1'b0;
      done_o        = 1'b0;
      fault_o       = 1'b0;
      fault_cause_o = 2'b00;
      bus_req_o     = 1'b0;
      case (state)
         IDLE: if (mem_en_i) begin
            if (illegal | misaligned) begin
               fault_o       = 1'b1;
               fault_cause_o = illegal ? 2'b10 : 2'b01;
            end else begin
               stall_o = 1'b1;
               state_n = REQ;
            end
         end
         REQ: begin
            stall_o = 1'b1;
            if (timeout) begin
               fault_o       = 1'b1;
               fault_cause_o = 2'b11;
               load_n        = 32'd0;
               state_n       = DONE;
            end else begin
               bus_req_o = 1'b1;
               if (bus_gnt_i) begin
                  state_n = we_q ? DONE : RESP;
                  load_n  = we_q ? 32'd0 : load_q;
               end
            end
         end
         RESP: begin
            stall_o = 1'b1;
            if (timeout) begin
               fault_o       = 1'b1;
               fault_cause_o = 2'b11;
               load_n        = 32'd0;
               state_n       = DONE;
            end else if (bus_rvalid_i) begin
               load_n  = ext;
               state_n = DONE;
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_n = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         cnt    <= '0;
         load_q <= '0;
         addr_q <= '0;
         wd_q   <= '0;
         f3_q   <= '0;
         we_q   <= 1'b0;
      end else begin
         state  <= state_n;
         load_q <= load_n;
         if (state == IDLE && state_n == REQ) begin
            cnt    <= '0;
            addr_q <= addr_i;
            wd_q   <= write_data_i;
            f3_q   <= funct3_i;
            we_q   <= mem_we_i;
         end else if (busy) begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks against a byte-lane reference model
module tb_mem_access_ctrl;
   localparam int TO = 256;
   logic clk = 1'b0, rst = 1'b1;
   logic mem_en = 1'b0, mem_we = 1'b0;
   logic [2:0] funct3 = 3'd0;
   logic [31:0] addr = 32'd0, wdata = 32'd0;
   logic stall_o, done_o, fault_o, bus_req_o, bus_we_o;
   logic [1:0] fault_cause_o;
   logic [31:0] load_data_o, bus_addr_o, bus_wdata_o;
   logic [3:0] bus_be_o;
   logic bus_gnt = 1'b0, bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = 32'd0;
   int checks = 0, errors = 0;
   logic [31:0] last_load = 32'd0;

   mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_i(rst), .mem_en_i(mem_en), .mem_we_i(mem_we), .funct3_i(funct3),
      .addr_i(addr), .write_data_i(wdata), .stall_o(stall_o), .done_o(done_o),
      .load_data_o(load_data_o), .fault_o(fault_o), .fault_cause_o(fault_cause_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
      .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int size_of(logic [2:0] f);
      return 1 << f[1:0];
   endfunction

   function automatic logic [1:0] exp_cause(bit we, logic [2:0] f, logic [31:0] a);
      bit ok = we ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!ok) return 2'b10;
      if (a % size_of(f) != 0) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [3:0] exp_be(logic [2:0] f, logic [31:0] a);
      logic [3:0] m = 4'd0;
      int off = int'(a % 4);
      for (int i = 0; i < 4; i++) m[i] = (i >= off) && (i < off + size_of(f));
      return m;
   endfunction

   function automatic logic [31:0] exp_wdata(logic [2:0] f, logic [31:0] wd);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % size_of(f)) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] exp_load(logic [2:0] f, logic [31:0] a, logic [31:0] rd);
      int n = size_of(f);
      longint v = longint'(rd >> (8 * (a % 4)));
      if (n < 4) begin
         v = v % (longint'(1) << (8 * n));
         if (!f[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      end
      return v[31:0];
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      @(negedge clk);
      checks++;
      if ({stall_o, done_o, fault_o, fault_cause_o, bus_req_o, bus_we_o, bus_be_o} !== 11'd0 ||
          load_data_o !== 32'd0 || bus_addr_o !== 32'd0 || bus_wdata_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs stall=%b done=%b fault=%b req=%b load=%h addr=%h expected all zero",
                  stall_o, done_o, fault_o, bus_req_o, load_data_o, bus_addr_o);
      end
      step();
      rst = 1'b0;
      last_load = 32'd0;
   endtask

   task automatic do_access(input bit we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int gd, input int rvd);
      logic [31:0] exp;
      mem_en = 1'b1; mem_we = we; funct3 = f; addr = a; wdata = wd;
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b1 || fault_o !== 1'b0 || bus_req_o !== 1'b0) begin
         errors++;
         $display("FAIL start stall=%b fault=%b req=%b expected 1 0 0", stall_o, fault_o, bus_req_o);
      end
      step();
      mem_en = 1'b0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
      for (int k = 0; k <= gd; k++) begin
         bus_gnt = (k == gd);
         bus_rvalid = (k != gd) && ($urandom % 2 == 1);
         @(negedge clk);
         checks++;
         if ({bus_req_o, stall_o, bus_we_o, done_o} !== {2'b11, we, 1'b0} || bus_addr_o !== (a & ~32'd3) ||
             bus_be_o !== exp_be(f, a) || bus_wdata_o !== exp_wdata(f, wd)) begin
            errors++;
            $display("FAIL req_phase req=%b stall=%b we=%b addr=%h be=%b wdata=%h expected 1 1 %b %h %b %h",
                     bus_req_o, stall_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
                     we, a & ~32'd3, exp_be(f, a), exp_wdata(f, wd));
         end
         step();
      end
      bus_gnt = 1'b0;
      bus_rvalid = 1'b0;
      if (!we) begin
         for (int j = 1; j <= rvd; j++) begin
            bus_rvalid = (j == rvd);
            bus_rdata = (j == rvd) ? rd : $urandom;
            @(negedge clk);
            checks++;
            if (stall_o !== 1'b1 || bus_req_o !== 1'b0 || done_o !== 1'b0) begin
               errors++;
               $display("FAIL resp_phase stall=%b req=%b done=%b expected 1 0 0", stall_o, bus_req_o, done_o);
            end
            step();
         end
         bus_rvalid = 1'b0;
      end
      exp = we ? 32'd0 : exp_load(f, a, rd);
      @(negedge clk);
      checks++;
      if (done_o !== 1'b1 || stall_o !== 1'b0 || fault_o !== 1'b0 || load_data_o !== exp) begin
         errors++;
         $display("FAIL done_phase done=%b stall=%b fault=%b load=%h expected 1 0 0 %h",
                  done_o, stall_o, fault_o, load_data_o, exp);
      end
      last_load = exp;
      step();
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || stall_o !== 1'b0 || load_data_o !== last_load) begin
         errors++;
         $display("FAIL after_done done=%b stall=%b load=%h expected 0 0 %h", done_o, stall_o, load_data_o, last_load);
      end
      step();
   endtask

   task automatic do_fault(input bit we, input logic [2:0] f, input logic [31:0] a);
      logic [1:0] c = exp_cause(we, f, a);
      mem_en = 1'b1; mem_we = we; funct3 = f; addr = a; wdata = $urandom;
      @(negedge clk);
      checks++;
      if (fault_o !== 1'b1 || fault_cause_o !== c || stall_o !== 1'b0 || bus_req_o !== 1'b0 ||
          load_data_o !== last_load) begin
         errors++;
         $display("FAIL fault fault=%b cause=%b stall=%b req=%b load=%h expected 1 %b 0 0 %h",
                  fault_o, fault_cause_o, stall_o, bus_req_o, load_data_o, c, last_load);
      end
      step();
      mem_en = 1'b0;
      @(negedge clk);
      checks++;
      if ({fault_o, fault_cause_o, stall_o, bus_req_o, done_o} !== 6'd0) begin
         errors++;
         $display("FAIL fault_idle fault=%b cause=%b stall=%b req=%b done=%b expected all zero",
                  fault_o, fault_cause_o, stall_o, bus_req_o, done_o);
      end
      step();
   endtask

   task automatic test_directed();
      do_access(1'b1, 3'b000, 32'h1003, 32'hAABBCCDD, 32'd0, 0, 1);
      do_access(1'b0, 3'b001, 32'h2002, 32'd0, 32'h8001_1234, 0, 3);
      checks++;
      if (load_data_o !== 32'hFFFF8001) begin
         errors++;
         $display("FAIL lh_value load=%h expected ffff8001", load_data_o);
      end
      do_access(1'b0, 3'b100, 32'h11, 32'd0, 32'h0000F000, 1, 1);
      checks++;
      if (load_data_o !== 32'h000000F0) begin
         errors++;
         $display("FAIL lbu_value load=%h expected 000000f0", load_data_o);
      end
      do_access(1'b0, 3'b000, 32'h11, 32'd0, 32'h0000F000, 2, 2);
      checks++;
      if (load_data_o !== 32'hFFFFFFF0) begin
         errors++;
         $display("FAIL lb_value load=%h expected fffffff0", load_data_o);
      end
      do_fault(1'b0, 3'b010, 32'h6);
      do_fault(1'b0, 3'b011, 32'h8);
      do_fault(1'b1, 3'b100, 32'h3);
   endtask

   task automatic test_timeout();
      int reqs = 0;
      mem_en = 1'b1; mem_we = 1'b1; funct3 = 3'b010; addr = 32'h40; wdata = 32'h1234_5678;
      step();
      mem_en = 1'b0;
      for (int k = 0; k < TO; k++) begin
         @(negedge clk);
         if (bus_req_o === 1'b1) reqs++;
         step();
      end
      checks++;
      if (reqs != TO) begin
         errors++;
         $display("FAIL timeout_req_cycles got=%0d expected %0d", reqs, TO);
      end
      @(negedge clk);
      checks++;
      if (fault_o !== 1'b1 || fault_cause_o !== 2'b11 || bus_req_o !== 1'b0 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_fault fault=%b cause=%b req=%b done=%b expected 1 11 0 0",
                  fault_o, fault_cause_o, bus_req_o, done_o);
      end
      step();
      @(negedge clk);
      checks++;
      if (done_o !== 1'b1 || fault_o !== 1'b0 || load_data_o !== 32'd0 || bus_req_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_done done=%b fault=%b load=%h req=%b expected 1 0 0 0",
                  done_o, fault_o, load_data_o, bus_req_o);
      end
      last_load = 32'd0;
      step();
      do_access(1'b1, 3'b010, 32'h80, 32'hCAFE_F00D, 32'd0, 0, 1);
   endtask

   task automatic test_reset_mid();
      mem_en = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h100;
      step();
      mem_en = 1'b0;
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0;
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b1 || bus_req_o !== 1'b0) begin
         errors++;
         $display("FAIL resp_before_reset stall=%b req=%b expected 1 0", stall_o, bus_req_o);
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({stall_o, done_o, fault_o, fault_cause_o, bus_req_o, bus_we_o, bus_be_o} !== 11'd0 ||
          load_data_o !== 32'd0 || bus_addr_o !== 32'd0 || bus_wdata_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid stall=%b done=%b req=%b load=%h expected all zero",
                  stall_o, done_o, bus_req_o, load_data_o);
      end
      last_load = 32'd0;
      step();
      for (int k = 0; k < 3; k++) begin
         bus_rvalid = 1'b1;
         bus_rdata = $urandom;
         @(negedge clk);
         checks++;
         if (done_o !== 1'b0 || stall_o !== 1'b0 || load_data_o !== 32'd0) begin
            errors++;
            $display("FAIL stray_rvalid done=%b stall=%b load=%h expected 0 0 0", done_o, stall_o, load_data_o);
         end
         step();
      end
      bus_rvalid = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         bit we = 1'($urandom % 2);
         logic [2:0] f = 3'($urandom);
         logic [31:0] a = $urandom;
         if ($urandom % 4 != 0) a[1:0] = 2'b00;
         if (exp_cause(we, f, a) == 2'b00)
            do_access(we, f, a, $urandom, $urandom, int'($urandom % 4), 1 + int'($urandom % 4));
         else
            do_fault(we, f, a);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_directed();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
